mnist_image_loader: RTL and testbench

//  Downstream consumer of the 28x28 drawing-grid image memory. On a start

---
 rtl/mnist_image_loader.sv | 125 ++++++++++++
 tb/tb_mnist_image_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mnist_image_loader.sv
// Frame reader for the drawing-grid memory: walks every cell in raster order,
// thresholds each word to a fixed-point pixel and streams it over valid/ready.
module mnist_image_loader #(
    parameter int GRID_SIZE  = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter logic signed [DATA_WIDTH-1:0] PIXEL_ONE = 256
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    output logic [ADDR_WIDTH-1:0]        mem_read_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_data_in,
    output logic signed [DATA_WIDTH-1:0] px_data,
    output logic [9:0]                   px_index,
    output logic                         px_valid,
    input  logic                         px_ready,
    output logic                         px_last,
    output logic                         busy,
    output logic                         done,
    output logic [9:0]                   ink_count
);

    localparam int         NUM_PIX  = GRID_SIZE * GRID_SIZE;
    localparam logic [9:0] LAST_IDX = 10'(NUM_PIX - 1);
    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        FINISH
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] idx;
    logic [9:0] run_count;
    logic [1:0] wait_cnt;
    logic       accept;
    logic       wait_done;
    logic       kill;

    assign accept    = px_valid && px_ready;
    // The counter is loaded with RD_LATENCY, so the final WAIT cycle sees 1.
    assign wait_done = (wait_cnt == 2'd1);
    assign kill      = abort && (state != IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = PRESENT;
            PRESENT: if (accept) state_nxt = px_last ? FINISH : ISSUE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mem_read_addr <= '0;
            px_data       <= '0;
            px_index      <= '0;
            px_valid      <= 1'b0;
            px_last       <= 1'b0;
            done          <= 1'b0;
            ink_count     <= '0;
            idx           <= '0;
            run_count     <= '0;
            wait_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                px_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            idx       <= '0;
                            run_count <= '0;
                        end
                    end
                    ISSUE: begin
                        mem_read_addr <= ADDR_WIDTH'(idx);
                        wait_cnt      <= WAIT_INIT;
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt - 2'd1;
                        if (wait_done) begin
                            // Any nonzero word, negative included, is ink.
                            px_data  <= (mem_data_in != '0) ? PIXEL_ONE : '0;
                            px_index <= idx;
                            px_last  <= (idx == LAST_IDX);
                            px_valid <= 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (accept) begin
                            px_valid <= 1'b0;
                            if (px_data != '0) run_count <= run_count + 10'd1;
                            if (!px_last) idx <= idx + 10'd1;
                        end
                    end
                    FINISH: begin
                        ink_count <= run_count;
                        done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mnist_image_loader.sv
// Randomized directed bench for mnist_image_loader: two instances (read latency 1 and 3)
// fed from one image array, checked against a per-index pixel model.
module tb_mnist_image_loader;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic resetn, start, abort, px_ready;
    logic [15:0] addr1, addr3;
    logic signed [31:0] mdat1, mdat3, pxd1, pxd3;
    logic [9:0] pxi1, pxi3, ink1, ink3;
    logic v1, v3, l1, l3, b1, b3, d1, d3;
    logic signed [31:0] mem [0:783];
    logic signed [31:0] p3a, p3b;
    int sel;
    int checks = 0;
    int failures = 0;

    always_comb mdat1 = (addr1 < 16'd784) ? mem[addr1] : 32'sd0;
    always @(posedge CLOCK_50) begin
        p3a <= (addr3 < 16'd784) ? mem[addr3] : 32'sd0;
        p3b <= p3a;
    end
    assign mdat3 = p3b;

    mnist_image_loader #(.RD_LATENCY(1)) dut1 (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .abort(abort),
        .mem_read_addr(addr1), .mem_data_in(mdat1), .px_data(pxd1), .px_index(pxi1),
        .px_valid(v1), .px_ready(px_ready), .px_last(l1), .busy(b1), .done(d1),
        .ink_count(ink1));

    mnist_image_loader #(.RD_LATENCY(3)) dut3 (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .abort(abort),
        .mem_read_addr(addr3), .mem_data_in(mdat3), .px_data(pxd3), .px_index(pxi3),
        .px_valid(v3), .px_ready(px_ready), .px_last(l3), .busy(b3), .done(d3),
        .ink_count(ink3));

    logic [15:0] addr;
    logic signed [31:0] pxd;
    logic [9:0] pxi, ink;
    logic v, l, b, d;
    assign addr = (sel == 3) ? addr3 : addr1;
    assign pxd  = (sel == 3) ? pxd3 : pxd1;
    assign pxi  = (sel == 3) ? pxi3 : pxi1;
    assign ink  = (sel == 3) ? ink3 : ink1;
    assign v    = (sel == 3) ? v3 : v1;
    assign l    = (sel == 3) ? l3 : l1;
    assign b    = (sel == 3) ? b3 : b1;
    assign d    = (sel == 3) ? d3 : d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_addr"}, 32'(addr), 0);
        chk({pfx, "_px_data"}, pxd, 0);
        chk({pfx, "_px_index"}, 32'(pxi), 0);
        chk({pfx, "_px_valid"}, 32'(v), 0);
        chk({pfx, "_px_last"}, 32'(l), 0);
        chk({pfx, "_busy"}, 32'(b), 0);
        chk({pfx, "_done"}, 32'(d), 0);
        chk({pfx, "_ink"}, 32'(ink), 0);
    endtask

    // One frame: model says pixel i is 256 when mem[i]!=0, else 0; last only at 783.
    task automatic run_frame(input bit rnd, input int abort_at, input bit spam, input int rl);
        int exp_i, cyc, last_acc, ink_exp, done_cnt;
        bit pv, pr, fin;
        logic signed [31:0] hd;
        logic [9:0] hi, prev_ink;
        logic hl;
        ink_exp = 0;
        foreach (mem[i]) if (mem[i] != 0) ink_exp++;
        prev_ink = ink;
        @(negedge CLOCK_50);
        start = 1'b1; abort = 1'b0;
        px_ready = rnd ? 1'($urandom % 2) : 1'b1;
        pr = px_ready; pv = 1'b0; hd = 0; hi = 0; hl = 0;
        exp_i = 0; cyc = 0; last_acc = 0; done_cnt = 0; fin = 1'b0;
        while (cyc < 20000 && !fin) begin
            @(negedge CLOCK_50);
            cyc++;
            start = (spam && exp_i < 784) ? 1'($urandom % 2) : 1'b0;
            if (d) done_cnt++;
            if (exp_i == 784 && done_cnt > 0) begin
                chk("done_count", done_cnt, 1);
                chk("ink_count", 32'(ink), ink_exp);
                chk("busy_after_done", 32'(b), 0);
                if (!rnd) chk("start_to_done", cyc, 784 * (rl + 2) + 2);
                @(negedge CLOCK_50);
                chk("done_one_cycle", 32'(d), 0);
                fin = 1'b1;
            end else begin
                if (v) begin
                    if (pv && !pr) begin
                        chk("hold_data", pxd, hd);
                        chk("hold_index", 32'(pxi), 32'(hi));
                        chk("hold_last", 32'(l), 32'(hl));
                    end
                    if (exp_i >= 784) chk("px_after_last", 32'(v), 0);
                    else if (exp_i == abort_at) begin
                        abort = 1'b1; px_ready = 1'b1;
                        @(negedge CLOCK_50);
                        abort = 1'b0;
                        chk("abort_valid", 32'(v), 0);
                        chk("abort_busy", 32'(b), 0);
                        chk("abort_done", 32'(d), 0);
                        chk("abort_ink", 32'(ink), 32'(prev_ink));
                        return;
                    end
                end
                pr = rnd ? 1'($urandom % 2) : 1'b1;
                px_ready = pr;
                if (v && pr && exp_i < 784) begin
                    chk("px_data", pxd, (mem[exp_i] != 0) ? 32'sd256 : 32'sd0);
                    chk("px_index", 32'(pxi), exp_i);
                    chk("px_last", 32'(l), 32'(exp_i == 783));
                    if (!rnd) chk("px_spacing", cyc - last_acc, (exp_i == 0) ? rl + 2 : rl + 2);
                    last_acc = cyc;
                    exp_i++;
                end
                pv = v; hd = pxd; hi = pxi; hl = l;
            end
        end
        start = 1'b0;
        if (!fin) chk("frame_timeout", exp_i, 785);
    endtask

    initial begin
        int k;
        sel = 1; start = 0; abort = 0; px_ready = 0; resetn = 0;
        foreach (mem[i]) mem[i] = 0;
        repeat (3) @(negedge CLOCK_50);
        chk_reset_vals("reset");
        resetn = 1;

        // start and abort together in IDLE: abort wins
        @(negedge CLOCK_50); start = 1; abort = 1;
        @(negedge CLOCK_50); start = 0; abort = 0;
        chk("start_abort_idle_busy", 32'(b), 0);

        // all-zero image, ready held high
        run_frame(0, -1, 0, 1);

        // three inked words
        mem[0] = 1; mem[405] = 1; mem[783] = 1;
        run_frame(0, -1, 0, 1);

        // random image, random back-pressure
        foreach (mem[i]) mem[i] = ($urandom % 4 == 0) ? $signed($urandom) : 0;
        run_frame(1, -1, 0, 1);

        // abort at pixel 300, then a full frame
        run_frame(1, 300, 0, 1);
        run_frame(1, -1, 0, 1);

        // async reset mid-PRESENT
        @(negedge CLOCK_50); start = 1; px_ready = 0;
        @(negedge CLOCK_50); start = 0;
        k = 0;
        while (!v && k < 50) begin @(negedge CLOCK_50); k++; end
        chk("reach_present", 32'(v), 1);
        #2 resetn = 0;
        #1 chk_reset_vals("async_reset");
        @(negedge CLOCK_50); resetn = 1;

        // start pulses while busy must not disturb the frame
        run_frame(1, -1, 1, 1);

        // latency 3 instance, one negative word
        resetn = 0;
        @(negedge CLOCK_50); resetn = 1;
        sel = 3;
        foreach (mem[i]) mem[i] = 0;
        mem[$urandom_range(0, 783)] = -5;
        run_frame(0, -1, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
